gate_result_checker: RTL and testbench
======================================

Name: gate_result_checker

Overview:
- Downstream consumer of the two-input logic gate block; samples its inputs (in_a, in_b) and its four outputs (and/or/xor/nand) on a qualifying strobe.
- Recomputes the expected results, counts samples and mismatches, tracks input-combination coverage, and latches the first failing vector.
- Synthesizable self-check stage; benches and on-chip debug read its status instead of eyeballing monitor output.

Parameters:
- CNT_W, 8, width of the sample and error counters; both saturate at 2^CNT_W-1.
- MIN_SAMPLES, 4, number of samples required, together with full coverage, before pass can assert.

Ports:
- clk  input  1  single clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous soft clear of all state; equivalent to reset.
- sample_valid  input  1  gate inputs/outputs on this cycle are to be checked.
- in_a  input  1  gate input A as driven to the gate.
- in_b  input  1  gate input B as driven to the gate.
- out_and  input  1  gate AND output.
- out_or  input  1  gate OR output.
- out_xor  input  1  gate XOR output.
- out_nand  input  1  gate NAND output.
- sample_count  output  CNT_W  number of checked samples (saturating).
- err_count  output  CNT_W  number of samples with at least one mismatch (saturating).
- err_flag  output  1  sticky; high once any mismatch is seen.
- first_err_vec  output  6  {in_a,in_b,out_and,out_or,out_xor,out_nand} of the first failing sample.
- first_err_mask  output  4  per-gate mismatch bits {and,or,xor,nand} of the first failing sample.
- coverage  output  4  bit k set once input combo {in_a,in_b}==k has been checked.
- pass  output  1  high in state PASS.

Behaviour:
- Reset (rst high, async): all outputs 0; pipeline valid bit 0; FSM in IDLE.
- clear (sampled at clk edge) has the same effect as reset on the next edge and overrides every other event on that edge:
  - A concurrent sample_valid is dropped.
  - Any sample held in stage 1 is discarded.
- Stage 1 (edge N): if sample_valid, register all six inputs and set s1_valid. Otherwise s1_valid clears.
- Stage 2 (edge N+1), when s1_valid is set:
  - Compute expected values: a&b, a|b, a^b, ~(a&b).
  - Form the 4-bit mismatch mask.
  - Update counters, coverage, first_err fields and FSM.
  - All outputs are registered, so results are visible 2 edges after the strobe.
- Back-to-back strobes are accepted every cycle with no bubbles; throughput is 1 sample/cycle.
- sample_count increments per checked sample; err_count increments when mask != 0. Both hold at the all-ones value with no wrap.
- first_err_vec/first_err_mask load only on the first mismatch after reset/clear (while err_flag is 0) and then hold.
- coverage[{a,b}] is set on every checked sample, including failing ones.
- FSM states and transitions (evaluated in stage 2):
  - IDLE -> RUN on the first checked sample, or -> FAULT if that sample mismatches.
  - RUN -> FAULT on any mismatch.
  - RUN -> PASS when coverage==4'hF and sample_count (after increment) >= MIN_SAMPLES with no mismatch.
  - PASS -> FAULT on any later mismatch; PASS otherwise holds while counting continues.
  - FAULT is terminal until clear/rst.
- err_flag is high exactly in FAULT. pass is high exactly in PASS. A mismatch on the same sample that completes coverage gives FAULT, never PASS.
- Reset asserted mid-stream: the in-flight sample is lost; no output glitches toward a stale value after rst deasserts.

Decomposition:
- Shared package gate_check_pkg:
  - typedef chk_state_e {IDLE, RUN, PASS, FAULT}.
  - typedef gate_vec_t: packed struct {a, b, and_o, or_o, xor_o, nand_o}.
  - Function gate_expect(a,b) returning the expected 4-bit {and,or,xor,nand}.
- One natural sub-module: sat_counter (parameter W; inc, clear; saturating). Instantiated twice.

Test Plan:
- Correct gate model driven 00,10,11,01 with sample_valid each cycle -> coverage 4'hF, sample_count=4, err_count=0, pass=1 two edges after the last strobe.
- On combo a=1,b=1, out_xor forced to 1 -> err_flag=1, err_count=1, first_err_vec=6'b111110, first_err_mask=4'b0010; FSM stays FAULT after a later good sweep.
- Two mismatches with different vectors -> first_err_vec/mask hold the first; err_count=2.
- 300 consecutive correct samples with CNT_W=8 -> sample_count saturates at 255; pass stays 1.
- clear asserted in the same cycle as sample_valid, with one sample in stage 1 -> all outputs 0 next edge, FSM IDLE, neither sample counted.
- rst pulsed asynchronously between edges mid-stream -> outputs 0 immediately. After release, a single correct sample gives sample_count=1, state RUN, pass=0.

Source files
------------

// File: rtl/gate_check_pkg.sv
// Shared types and the reference gate model used by the result checker.
package gate_check_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PASS  = 2'd2,
    FAULT = 2'd3
  } chk_state_e;

  typedef struct packed {
    logic a;
    logic b;
    logic and_o;
    logic or_o;
    logic xor_o;
    logic nand_o;
  } gate_vec_t;

  // Expected {and,or,xor,nand} for inputs a,b
  function automatic logic [3:0] gate_expect(input logic a, input logic b);
    return {a & b, a | b, a ^ b, ~(a & b)};
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; exposes its next value for
// consumers that must decide on the post-increment count in the same cycle.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic [W-1:0] count_nxt
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear)
      count_d = '0;
    else if (inc && (count_q != {W{1'b1}}))
      count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count     = count_q;
  assign count_nxt = count_d;

endmodule

// File: rtl/gate_result_checker.sv
// Two-stage checker for the 2-input gate block: stage 1 captures a strobed
// vector, stage 2 compares it against the reference model and updates status.
module gate_result_checker
  import gate_check_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int MIN_SAMPLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             sample_valid,
  input  logic             in_a,
  input  logic             in_b,
  input  logic             out_and,
  input  logic             out_or,
  input  logic             out_xor,
  input  logic             out_nand,
  output logic [CNT_W-1:0] sample_count,
  output logic [CNT_W-1:0] err_count,
  output logic             err_flag,
  output logic [5:0]       first_err_vec,
  output logic [3:0]       first_err_mask,
  output logic [3:0]       coverage,
  output logic             pass
);

  localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_SAMPLES);

  gate_vec_t  in_vec;
  gate_vec_t  s1_vec_q, s1_vec_d;
  logic       s1_valid_q, s1_valid_d;
  gate_vec_t  first_vec_q, first_vec_d;
  logic [3:0] first_mask_q, first_mask_d;
  logic [3:0] cov_q, cov_d;
  chk_state_e state_q, state_d;

  logic             fire, mism;
  logic [3:0]       exp_res, mask;
  logic [CNT_W-1:0] smp_nxt, err_nxt;

  assign in_vec = '{a: in_a, b: in_b, and_o: out_and, or_o: out_or,
                    xor_o: out_xor, nand_o: out_nand};

  // Stage-2 compare; clear suppresses it so nothing in flight gets counted
  assign fire    = s1_valid_q && !clear;
  assign exp_res = gate_expect(s1_vec_q.a, s1_vec_q.b);
  assign mask    = exp_res ^ {s1_vec_q.and_o, s1_vec_q.or_o, s1_vec_q.xor_o, s1_vec_q.nand_o};
  assign mism    = fire && (mask != 4'b0);

  sat_counter #(.W(CNT_W)) u_smp_cnt (
    .clk(clk), .rst(rst), .clear(clear), .inc(fire),
    .count(sample_count), .count_nxt(smp_nxt)
  );

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk(clk), .rst(rst), .clear(clear), .inc(mism),
    .count(err_count), .count_nxt(err_nxt)
  );

  always_comb begin
    s1_valid_d   = sample_valid;
    s1_vec_d     = sample_valid ? in_vec : s1_vec_q;
    cov_d        = cov_q;
    first_vec_d  = first_vec_q;
    first_mask_d = first_mask_q;
    state_d      = state_q;

    if (fire)
      cov_d[{s1_vec_q.a, s1_vec_q.b}] = 1'b1;

    // Only the first failure after reset/clear is latched
    if (mism && (state_q != FAULT)) begin
      first_vec_d  = s1_vec_q;
      first_mask_d = mask;
    end

    if (fire) begin
      unique case (state_q)
        IDLE:    state_d = mism ? FAULT : RUN;
        RUN: begin
          if (mism)
            state_d = FAULT;
          else if ((cov_d == 4'hF) && (smp_nxt >= MIN_CNT))
            state_d = PASS;
        end
        PASS:    if (mism) state_d = FAULT;
        FAULT:   state_d = FAULT;
        default: state_d = IDLE;
      endcase
    end

    if (clear) begin
      s1_valid_d   = 1'b0;
      s1_vec_d     = '0;
      cov_d        = '0;
      first_vec_d  = '0;
      first_mask_d = '0;
      state_d      = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_vec_q     <= '0;
      cov_q        <= '0;
      first_vec_q  <= '0;
      first_mask_q <= '0;
      state_q      <= IDLE;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_vec_q     <= s1_vec_d;
      cov_q        <= cov_d;
      first_vec_q  <= first_vec_d;
      first_mask_q <= first_mask_d;
      state_q      <= state_d;
    end
  end

  assign err_flag       = (state_q == FAULT);
  assign pass           = (state_q == PASS);
  assign coverage       = cov_q;
  assign first_err_vec  = first_vec_q;
  assign first_err_mask = first_mask_q;

endmodule

// File: tb/tb_gate_result_checker.sv
// Directed bench for gate_result_checker: hand-computed expectations checked
// with immediate assertions after each step.
module tb_gate_result_checker;
  import gate_check_pkg::*;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             clear;
  logic             sample_valid;
  logic             in_a, in_b;
  logic             out_and, out_or, out_xor, out_nand;
  logic [CNT_W-1:0] sample_count, err_count;
  logic             err_flag, pass;
  logic [5:0]       first_err_vec;
  logic [3:0]       first_err_mask, coverage;

  int checks = 0;
  int errors = 0;

  gate_result_checker #(.CNT_W(CNT_W), .MIN_SAMPLES(4)) dut (
    .clk(clk), .rst(rst), .clear(clear), .sample_valid(sample_valid),
    .in_a(in_a), .in_b(in_b), .out_and(out_and), .out_or(out_or),
    .out_xor(out_xor), .out_nand(out_nand),
    .sample_count(sample_count), .err_count(err_count), .err_flag(err_flag),
    .first_err_vec(first_err_vec), .first_err_mask(first_err_mask),
    .coverage(coverage), .pass(pass)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Drive one cycle; flip XORs the correct {and,or,xor,nand} to inject faults
  task automatic step(input logic v, input logic a, input logic b, input logic [3:0] flip);
    sample_valid = v;
    in_a = a;
    in_b = b;
    {out_and, out_or, out_xor, out_nand} = {a & b, a | b, a ^ b, ~(a & b)} ^ flip;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 4'b0);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    idle();
    clear = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; sample_valid = 1'b0;
    in_a = 0; in_b = 0; out_and = 0; out_or = 0; out_xor = 0; out_nand = 0;
    #12;
    chk("rst_cnt",  32'(sample_count), 0);
    chk("rst_err",  32'(err_flag), 0);
    chk("rst_cov",  32'(coverage), 0);
    chk("rst_pass", 32'(pass), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Good sweep 00,10,11,01
    step(1, 0, 0, 4'b0);
    step(1, 1, 0, 4'b0);
    step(1, 1, 1, 4'b0);
    step(1, 0, 1, 4'b0);
    chk("sweep_mid_cnt",  32'(sample_count), 3);
    chk("sweep_mid_pass", 32'(pass), 0);
    idle();
    chk("sweep_cov",  32'(coverage), 32'hF);
    chk("sweep_cnt",  32'(sample_count), 4);
    chk("sweep_errc", 32'(err_count), 0);
    chk("sweep_pass", 32'(pass), 1);
    chk("sweep_flag", 32'(err_flag), 0);

    // Single xor fault on 11, then a good sweep
    do_clear();
    chk("clr_cnt", 32'(sample_count), 0);
    chk("clr_pass", 32'(pass), 0);
    step(1, 1, 1, 4'b0010);
    step(1, 0, 0, 4'b0);
    step(1, 1, 0, 4'b0);
    step(1, 1, 1, 4'b0);
    step(1, 0, 1, 4'b0);
    idle();
    chk("f1_flag", 32'(err_flag), 1);
    chk("f1_errc", 32'(err_count), 1);
    chk("f1_vec",  32'(first_err_vec), 32'b111110);
    chk("f1_mask", 32'(first_err_mask), 32'b0010);
    chk("f1_pass", 32'(pass), 0);
    chk("f1_cnt",  32'(sample_count), 5);
    chk("f1_cov",  32'(coverage), 32'hF);

    // Two different faults: first one must be held
    do_clear();
    step(1, 0, 1, 4'b1000);
    step(1, 1, 0, 4'b0001);
    idle();
    chk("f2_errc", 32'(err_count), 2);
    chk("f2_vec",  32'(first_err_vec), 32'b011111);
    chk("f2_mask", 32'(first_err_mask), 32'b1000);
    chk("f2_flag", 32'(err_flag), 1);

    // Saturation over 300 good samples
    do_clear();
    for (int i = 0; i < 300; i++)
      step(1, i[1], i[0], 4'b0);
    idle();
    chk("sat_cnt",  32'(sample_count), 255);
    chk("sat_pass", 32'(pass), 1);
    chk("sat_errc", 32'(err_count), 0);

    // clear concurrent with a strobe while stage 1 holds a sample
    step(1, 0, 0, 4'b0);
    clear = 1'b1;
    step(1, 1, 0, 4'b0);
    clear = 1'b0;
    chk("cc_cnt",  32'(sample_count), 0);
    chk("cc_cov",  32'(coverage), 0);
    chk("cc_pass", 32'(pass), 0);
    chk("cc_vec",  32'(first_err_vec), 0);
    idle();
    chk("cc_cnt2", 32'(sample_count), 0);
    chk("cc_cov2", 32'(coverage), 0);
    chk("cc_st",   32'(dut.state_q), 32'(IDLE));

    // Async reset mid-stream
    step(1, 1, 1, 4'b0);
    step(1, 0, 1, 4'b0100);
    idle();
    idle();
    chk("ar_pre_cnt",  32'(sample_count), 2);
    chk("ar_pre_flag", 32'(err_flag), 1);
    step(1, 0, 0, 4'b0);
    #2 rst = 1'b1;
    #1;
    chk("ar_cnt",  32'(sample_count), 0);
    chk("ar_flag", 32'(err_flag), 0);
    chk("ar_errc", 32'(err_count), 0);
    chk("ar_vec",  32'(first_err_vec), 0);
    #1 rst = 1'b0;
    sample_valid = 1'b0;
    @(posedge clk); #1;
    chk("ar_lost", 32'(sample_count), 0);
    step(1, 1, 0, 4'b0);
    idle();
    chk("ar_one_cnt",  32'(sample_count), 1);
    chk("ar_one_st",   32'(dut.state_q), 32'(RUN));
    chk("ar_one_pass", 32'(pass), 0);
    chk("ar_one_cov",  32'(coverage), 32'b0100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
